// File: rtl/dsp_cast_pkg.sv
// Shared signed width-cast helpers for the DSP datapath: rounding/saturation
// mode encodings, signed range bounds and a carry-safe round-and-shift.
package dsp_cast_pkg;

  localparam int unsigned CAST_TRUNC = 0;
  localparam int unsigned CAST_ROUND = 1;
  localparam int unsigned CAST_WRAP  = 0;
  localparam int unsigned CAST_SAT   = 1;

  // Working width for helper arithmetic; wide enough for any legal sample plus carry
  localparam int unsigned CAST_MAX_W = 64;

  typedef logic signed [CAST_MAX_W-1:0] cast_word_t;

  typedef struct packed {
    cast_word_t hi;
    cast_word_t lo;
  } cast_bounds_t;

  function automatic cast_bounds_t sat_bounds(input int unsigned width);
    cast_bounds_t b;
    b.hi = (cast_word_t'(1) <<< (width - 32'd1)) - cast_word_t'(1);
    b.lo = -(cast_word_t'(1) <<< (width - 32'd1));
    return b;
  endfunction

  // Round-half-up (optional) then arithmetic shift; floor when rounding is off
  function automatic cast_word_t round_shift(input cast_word_t value,
                                             input int unsigned shift,
                                             input logic round_en);
    cast_word_t v;
    v = value;
    if (round_en && (shift != 32'd0)) begin
      v = v + (cast_word_t'(1) <<< (shift - 32'd1));
    end
    return v >>> shift;
  endfunction

endpackage

// File: rtl/bit_width_cast_stream_if.sv
// Valid/ready stream bundle for the width caster: sample input side plus
// converted output side with its saturation flag.
interface bit_width_cast_stream_if #(
  parameter int unsigned INPUT_WIDTH  = 32,
  parameter int unsigned OUTPUT_WIDTH = 16
);

  logic                    s_valid;
  logic                    s_ready;
  logic [INPUT_WIDTH-1:0]  s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [OUTPUT_WIDTH-1:0] m_data;
  logic                    m_sat;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sat
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sat
  );

endinterface

// File: rtl/cast_sat_stage.sv
// Combinational range check of a signed value against OUT_WIDTH, with
// clamp (and flag) or plain low-bit wrap.
module cast_sat_stage
  import dsp_cast_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 33,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SAT_EN    = CAST_SAT
) (
  input  logic [IN_WIDTH-1:0]  r_i,
  output logic [OUT_WIDTH-1:0] data_c_o,
  output logic                 sat_c_o
);

  localparam cast_bounds_t BOUNDS = sat_bounds(OUT_WIDTH);

  cast_word_t r_ext;

  always_comb begin
    r_ext    = cast_word_t'($signed(r_i));
    data_c_o = OUT_WIDTH'(r_ext);
    sat_c_o  = 1'b0;
    if (SAT_EN == CAST_SAT) begin
      if (r_ext > BOUNDS.hi) begin
        data_c_o = OUT_WIDTH'(BOUNDS.hi);
        sat_c_o  = 1'b1;
      end else if (r_ext < BOUNDS.lo) begin
        data_c_o = OUT_WIDTH'(BOUNDS.lo);
        sat_c_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_width_cast_stream.sv
// Two-stage valid/ready signed width caster: round/shift, then clamp or wrap,
// with a sticky-at-max counter of accepted saturated outputs.
module bit_width_cast_stream
  import dsp_cast_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = 32,
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned SHIFT        = 16,
  parameter int unsigned ROUND_EN     = CAST_ROUND,
  parameter int unsigned SAT_EN       = CAST_SAT,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bit_width_cast_stream_if.slave bus,
  input  logic                 sat_cnt_clr,
  output logic [CNT_WIDTH-1:0] sat_cnt
);

  // One extra bit keeps the rounding carry of the most positive input
  localparam int unsigned         R_WIDTH = INPUT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if ((INPUT_WIDTH < 2) || (OUTPUT_WIDTH < 2) || (SHIFT >= INPUT_WIDTH) ||
      (INPUT_WIDTH >= CAST_MAX_W) || (OUTPUT_WIDTH > CAST_MAX_W) || (CNT_WIDTH < 1)) begin : g_bad_params
    $error("bit_width_cast_stream: illegal width/shift parameters");
  end

  logic                    en_c;
  logic                    v1_q;
  logic [R_WIDTH-1:0]      r_q, r_d;
  logic                    m_valid_q;
  logic [OUTPUT_WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_sat_q, m_sat_d;
  logic [CNT_WIDTH-1:0]    sat_cnt_q, sat_cnt_d;

  assign en_c        = !m_valid_q || bus.m_ready;
  assign bus.s_ready = en_c;

  always_comb begin
    r_d = R_WIDTH'(round_shift(cast_word_t'($signed(bus.s_data)), SHIFT,
                               (ROUND_EN == CAST_ROUND)));
  end

  cast_sat_stage #(
    .IN_WIDTH  (R_WIDTH),
    .OUT_WIDTH (OUTPUT_WIDTH),
    .SAT_EN    (SAT_EN)
  ) u_cast_sat_stage (
    .r_i      (r_q),
    .data_c_o (m_data_d),
    .sat_c_o  (m_sat_d)
  );

  // Clear wins over a same-cycle saturated accept
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_cnt_clr) begin
      sat_cnt_d = '0;
    end else if (m_valid_q && bus.m_ready && m_sat_q && (sat_cnt_q != CNT_MAX)) begin
      sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      r_q       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sat_q   <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      if (en_c) begin
        v1_q      <= bus.s_valid;
        r_q       <= r_d;
        m_valid_q <= v1_q;
        m_data_q  <= m_data_d;
        m_sat_q   <= m_sat_d;
      end
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_sat   = m_sat_q;
  assign sat_cnt     = sat_cnt_q;

endmodule

// File: tb/tb_bit_width_cast_stream.sv
// Bench for bit_width_cast_stream: four configurations driven in lockstep,
// checked against an arithmetic reference model plus pinned literal vectors.
module tb_bit_width_cast_stream;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        m_ready;
  logic        clr;
  logic [31:0] s32;
  logic [11:0] s12;

  int checks   = 0;
  int failures = 0;
  logic started = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A: defaults; B: truncate, 12-bit out, 2-bit counter; C: wrap; D: 12->20 identity
  bit_width_cast_stream_if #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(16)) ifa ();
  bit_width_cast_stream_if #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(12)) ifb ();
  bit_width_cast_stream_if #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(16)) ifc ();
  bit_width_cast_stream_if #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(20)) ifd ();

  assign ifa.s_valid = s_valid; assign ifa.s_data = s32; assign ifa.m_ready = m_ready;
  assign ifb.s_valid = s_valid; assign ifb.s_data = s32; assign ifb.m_ready = m_ready;
  assign ifc.s_valid = s_valid; assign ifc.s_data = s32; assign ifc.m_ready = m_ready;
  assign ifd.s_valid = s_valid; assign ifd.s_data = s12; assign ifd.m_ready = m_ready;

  logic [15:0] cnt_a, cnt_c, cnt_d;
  logic [1:0]  cnt_b;

  bit_width_cast_stream #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(16), .SHIFT(16), .ROUND_EN(1),
                          .SAT_EN(1), .CNT_WIDTH(16))
    dut_a (.clk(clk), .rst(rst), .bus(ifa), .sat_cnt_clr(clr), .sat_cnt(cnt_a));
  bit_width_cast_stream #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(12), .SHIFT(16), .ROUND_EN(0),
                          .SAT_EN(1), .CNT_WIDTH(2))
    dut_b (.clk(clk), .rst(rst), .bus(ifb), .sat_cnt_clr(clr), .sat_cnt(cnt_b));
  bit_width_cast_stream #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(16), .SHIFT(16), .ROUND_EN(1),
                          .SAT_EN(0), .CNT_WIDTH(16))
    dut_c (.clk(clk), .rst(rst), .bus(ifc), .sat_cnt_clr(clr), .sat_cnt(cnt_c));
  bit_width_cast_stream #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(20), .SHIFT(0), .ROUND_EN(1),
                          .SAT_EN(1), .CNT_WIDTH(16))
    dut_d (.clk(clk), .rst(rst), .bus(ifd), .sat_cnt_clr(clr), .sat_cnt(cnt_d));

  logic [3:0]       mv, ms, sr;
  logic [3:0][31:0] md;
  logic [3:0][15:0] sc;

  assign mv = {ifd.m_valid, ifc.m_valid, ifb.m_valid, ifa.m_valid};
  assign ms = {ifd.m_sat, ifc.m_sat, ifb.m_sat, ifa.m_sat};
  assign sr = {ifd.s_ready, ifc.s_ready, ifb.s_ready, ifa.s_ready};
  assign md = {32'(ifd.m_data), 32'(ifc.m_data), 32'(ifb.m_data), 32'(ifa.m_data)};
  assign sc = {cnt_d, cnt_c, 16'(cnt_b), cnt_a};

  typedef struct packed {
    logic [3:0]       msat;
    logic [3:0][31:0] mdata;
    logic             has_lit;
    logic [3:0]       lsat;
    logic [3:0][31:0] ldata;
  } exp_t;

  exp_t             q[$];
  int               cnt_m[4];
  logic             lit_en;
  logic [3:0]       lit_s;
  logic [3:0][31:0] lit_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: add half LSB if rounding, floor-divide by 2^shift, then clamp or wrap
  function automatic logic [32:0] model(input int k, input logic [31:0] x, input logic [11:0] y);
    int ow, sh, re, se;
    longint r, mx, mn;
    logic sat;
    case (k)
      0:       begin ow = 16; sh = 16; re = 1; se = 1; r = longint'($signed(x)); end
      1:       begin ow = 12; sh = 16; re = 0; se = 1; r = longint'($signed(x)); end
      2:       begin ow = 16; sh = 16; re = 1; se = 0; r = longint'($signed(x)); end
      default: begin ow = 20; sh = 0;  re = 1; se = 1; r = longint'($signed(y)); end
    endcase
    if (re != 0 && sh > 0) r = r + (64'sd1 <<< (sh - 1));
    r   = r >>> sh;
    mx  = (64'sd1 <<< (ow - 1)) - 64'sd1;
    mn  = -(64'sd1 <<< (ow - 1));
    sat = 1'b0;
    if (se != 0 && r > mx) begin r = mx; sat = 1'b1; end
    if (se != 0 && r < mn) begin r = mn; sat = 1'b1; end
    return {sat, 32'(r & ((64'sd1 <<< ow) - 64'sd1))};
  endfunction

  // Scoreboard and counter model update on handshakes
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (clr) cnt_m[k] = 0;
        else if (mv[0] && m_ready && q.size() > 0 && q[0].msat[k] &&
                 cnt_m[k] < ((k == 1) ? 3 : 65535)) cnt_m[k] = cnt_m[k] + 1;
      end
      if (mv[0] && m_ready && q.size() > 0) void'(q.pop_front());
      if (s_valid && sr[0]) begin
        exp_t e;
        for (int k = 0; k < 4; k++) {e.msat[k], e.mdata[k]} = model(k, s32, s12);
        e.has_lit = lit_en;
        e.lsat    = lit_s;
        e.ldata   = lit_d;
        q.push_back(e);
      end
    end
  end

  // Compare every valid output and every counter against the model
  always @(negedge clk) begin
    if (started && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (mv[k] === 1'b1) begin
          chk($sformatf("dut%0d output has pending sample", k), 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            chk($sformatf("dut%0d m_data vs model", k), md[k], q[0].mdata[k]);
            chk($sformatf("dut%0d m_sat vs model", k), 32'(ms[k]), 32'(q[0].msat[k]));
            if (q[0].has_lit) begin
              chk($sformatf("dut%0d m_data literal", k), md[k], q[0].ldata[k]);
              chk($sformatf("dut%0d m_sat literal", k), 32'(ms[k]), 32'(q[0].lsat[k]));
            end
          end
        end
        chk($sformatf("dut%0d sat_cnt vs model", k), 32'(sc[k]), 32'(cnt_m[k]));
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [11:0] y);
    int budget;
    budget  = 0;
    s_valid = 1'b1;
    s32     = x;
    s12     = y;
    #1;
    while (sr[0] !== 1'b1) begin
      @(negedge clk);
      #1;
      budget++;
      if (budget > 100) begin
        checks++;
        failures++;
        $display("FAIL send accept: actual=stalled required=s_ready within 100 cycles");
        break;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    lit_en  = 1'b0;
  endtask

  task automatic send_pin(input logic [31:0] x, input logic [11:0] y,
                          input logic [31:0] la, input logic [31:0] lb,
                          input logic [31:0] lc, input logic [31:0] ld, input logic [3:0] ls);
    lit_en = 1'b1;
    lit_d  = {ld, lc, lb, la};
    lit_s  = ls;
    send(x, y);
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] held;

  initial begin
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; clr = 1'b0; s32 = '0; s12 = '0;
    lit_en = 1'b0; lit_s = '0; lit_d = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    started = 1'b1;
    chk("reset m_valid", 32'(mv), 32'h0);
    chk("reset m_data", md[0], 32'h0);
    chk("reset m_sat", 32'(ms), 32'h0);
    chk("reset sat_cnt", 32'(sc[0]), 32'h0);
    chk("reset s_ready", 32'(sr), 32'hF);

    // Round-half-up vs truncate, checked with its two-cycle latency
    send_pin(32'h0001_8000, 12'h800, 32'h0002, 32'h001, 32'h0002, 32'hFF800, 4'b0000);
    chk("latency one cycle after accept", 32'(mv[0]), 32'd0);
    @(negedge clk);
    chk("latency two cycles after accept", 32'(mv[0]), 32'd1);
    chk("first output A", md[0], 32'h0002);
    send_pin(32'h7FFF_8000, 12'h7FF, 32'h7FFF, 32'h7FF, 32'h8000, 32'h007FF, 4'b0011);
    send_pin(32'hFFFF_7FFF, 12'h000, 32'hFFFF, 32'hFFF, 32'hFFFF, 32'h00000, 4'b0000);
    send_pin(32'h8000_0000, 12'h001, 32'h8000, 32'h800, 32'h8000, 32'h00001, 4'b0010);
    drain(6);
    chk("sat_cnt A after vectors", 32'(sc[0]), 32'd1);
    chk("sat_cnt B after vectors", 32'(sc[1]), 32'd2);

    // Ramp with a three-cycle downstream stall in the middle
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'(i + 10) << 16, 12'(i + 10));
      end
      begin
        repeat (4) @(negedge clk);
        m_ready = 1'b0;
        #1;
        held = md[0];
        chk("stall m_valid", 32'(mv[0]), 32'd1);
        chk("stall s_ready", 32'(sr), 32'h0);
        repeat (2) begin
          @(negedge clk);
          #1;
          chk("stall s_ready", 32'(sr), 32'h0);
          chk("stall m_data held", md[0], held);
        end
        @(negedge clk);
        m_ready = 1'b1;
      end
    join
    drain(6);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clear sat_cnt A", 32'(sc[0]), 32'd0);
    chk("clear sat_cnt B", 32'(sc[1]), 32'd0);

    // Clear coincides with the third saturated accept
    for (int i = 0; i < 3; i++) send(32'h7FFF_8000, 12'h7FF);
    @(negedge clk);
    chk("sat_cnt before clear", 32'(sc[0]), 32'd2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clear beats increment A", 32'(sc[0]), 32'd0);
    chk("clear beats increment B", 32'(sc[1]), 32'd0);

    // Counter sticks at all-ones on the 2-bit instance
    for (int i = 0; i < 5; i++) send(32'h7FFF_8000, 12'h7FF);
    drain(6);
    chk("sat_cnt A five", 32'(sc[0]), 32'd5);
    chk("sat_cnt B sticks", 32'(sc[1]), 32'd3);

    // Reset with two samples stuck in the pipeline
    m_ready = 1'b0;
    send(32'h0003_0000, 12'h003);
    send(32'h0004_0000, 12'h004);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    chk("reset flush m_valid", 32'(mv), 32'h0);
    chk("reset flush sat_cnt", 32'(sc[0]), 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("no stale output", 32'(mv), 32'h0);
    end
    chk("scoreboard empty after reset", 32'(q.size()), 32'd0);
    chk("s_ready after reset", 32'(sr), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
